// File: rtl/time_keeper.sv
// BCD time-of-day counter (HH:MM:SS) advanced by the 1 Hz tick, with a
// RUN / SET_HR / SET_MIN mode machine for setting hours and minutes.
module time_keeper #(
    parameter logic [7:0] INIT_HR  = 8'h00,
    parameter logic [7:0] INIT_MIN = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       mode,
    input  logic       inc,
    output logic [7:0] hr_bcd,
    output logic [7:0] min_bcd,
    output logic [7:0] sec_bcd,
    output logic [1:0] state,
    output logic       day_pulse
);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10
    } mode_t;

    mode_t      state_q, state_d;
    logic [7:0] hr_q, hr_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic       day_q, day_d;

    // Wraps at (or beyond) the field maximum so a corrupt value self-heals to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
        if (v >= max)
            return 8'h00;
        else if (v[3:0] >= 4'd9)
            return {v[7:4] + 4'd1, 4'd0};
        else
            return {v[7:4], v[3:0] + 4'd1};
    endfunction

    always_comb begin
        state_d = state_q;
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        day_d   = 1'b0;
        case (state_q)
            RUN: begin
                if (mode)
                    state_d = SET_HR;
                // A tick coinciding with mode is still applied before freezing.
                if (tick) begin
                    sec_d = bcd_inc(sec_q, 8'h59);
                    if (sec_q == 8'h59) begin
                        min_d = bcd_inc(min_q, 8'h59);
                        if (min_q == 8'h59) begin
                            hr_d = bcd_inc(hr_q, 8'h23);
                            if (hr_q == 8'h23)
                                day_d = 1'b1;
                        end
                    end
                end
            end
            SET_HR: begin
                if (mode)
                    state_d = SET_MIN;
                else if (inc)
                    hr_d = bcd_inc(hr_q, 8'h23);
            end
            SET_MIN: begin
                if (mode) begin
                    state_d = RUN;
                    sec_d   = 8'h00;
                end else if (inc) begin
                    min_d = bcd_inc(min_q, 8'h59);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= RUN;
            hr_q    <= INIT_HR;
            min_q   <= INIT_MIN;
            sec_q   <= 8'h00;
            day_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            day_q   <= day_d;
        end
    end

    assign hr_bcd    = hr_q;
    assign min_bcd   = min_q;
    assign sec_bcd   = sec_q;
    assign state     = state_q;
    assign day_pulse = day_q;

endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper: reset load, ticking, set mode, digit
// carries, day rollover, same-cycle input priority and reset mid-set.
module tb_time_keeper;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       mode = 1'b0;
    logic       inc = 1'b0;
    logic [7:0] hr_bcd, min_bcd, sec_bcd;
    logic [1:0] state;
    logic       day_pulse;

    int tests = 0;
    int failed = 0;

    time_keeper #(.INIT_HR(8'h12), .INIT_MIN(8'h34)) dut (
        .clk(clk), .rst(rst), .tick(tick), .mode(mode), .inc(inc),
        .hr_bcd(hr_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
        .state(state), .day_pulse(day_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] now();
        return {8'h00, hr_bcd, min_bcd, sec_bcd};
    endfunction

    function automatic logic bcd_ok();
        return (hr_bcd[3:0] <= 4'd9) && (min_bcd[3:0] <= 4'd9) && (sec_bcd[3:0] <= 4'd9) &&
               (hr_bcd <= 8'h23) && (min_bcd <= 8'h59) && (sec_bcd <= 8'h59);
    endfunction

    // Drive one cycle of inputs, then sample 1 time unit after the edge.
    task automatic cyc(input logic t, input logic m, input logic i);
        tick = t; mode = m; inc = i;
        @(posedge clk);
        #1;
        tick = 1'b0; mode = 1'b0; inc = 1'b0;
    endtask

    task automatic incs(input int n);
        for (int k = 0; k < n; k++) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic ticks(input int n, input string tag);
        for (int k = 0; k < n; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            chk({tag, "_day"}, {31'd0, day_pulse}, 32'd0);
            chk({tag, "_bcd"}, {31'd0, bcd_ok()}, 32'd1);
        end
    endtask

    initial begin
        // Reset load
        rst = 1'b0;
        cyc(1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("reset_time", now(), 32'h00123400);
        chk("reset_state", {30'd0, state}, 32'd0);
        chk("reset_day", {31'd0, day_pulse}, 32'd0);
        rst = 1'b1;

        ticks(5, "run5");
        chk("run5_time", now(), 32'h00123405);
        chk("run5_state", {30'd0, state}, 32'd0);

        // Preload 23:59 via set mode
        cyc(1'b0, 1'b1, 1'b0);
        chk("pre_state_hr", {30'd0, state}, 32'd1);
        incs(11);
        chk("pre_hr", now(), 32'h00233405);
        cyc(1'b0, 1'b1, 1'b0);
        chk("pre_state_min", {30'd0, state}, 32'd2);
        incs(25);
        chk("pre_min", now(), 32'h00235905);
        cyc(1'b1, 1'b0, 1'b0);
        chk("setmin_tick_frozen", now(), 32'h00235905);
        cyc(1'b1, 1'b1, 1'b0);
        chk("setmin_mode_tick_time", now(), 32'h00235900);
        chk("setmin_mode_tick_state", {30'd0, state}, 32'd0);

        // Day rollover with back-to-back ticks
        ticks(59, "roll_pre");
        chk("roll_235959", now(), 32'h00235959);
        cyc(1'b1, 1'b0, 1'b0);
        chk("roll_000000", now(), 32'h00000000);
        chk("roll_day_hi", {31'd0, day_pulse}, 32'd1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("roll_000001", now(), 32'h00000001);
        chk("roll_day_lo", {31'd0, day_pulse}, 32'd0);

        // Set-mode wraps
        cyc(1'b0, 1'b1, 1'b0);
        incs(23);
        chk("hr_23", {24'd0, hr_bcd}, 32'h23);
        incs(1);
        chk("hr_wrap", {24'd0, hr_bcd}, 32'h00);
        chk("hr_wrap_day", {31'd0, day_pulse}, 32'd0);
        incs(1);
        cyc(1'b1, 1'b0, 1'b0);
        chk("sethr_tick_frozen", now(), 32'h00010001);
        cyc(1'b0, 1'b1, 1'b0);
        incs(59);
        chk("min_59", {24'd0, min_bcd}, 32'h59);
        incs(1);
        chk("min_wrap", now(), 32'h00010001);
        incs(1);
        chk("min_01", now(), 32'h00010101);
        cyc(1'b0, 1'b1, 1'b0);
        chk("exit_set", now(), 32'h00010100);
        chk("exit_set_state", {30'd0, state}, 32'd0);

        // Carry 00:00:09 -> 00:00:10
        cyc(1'b0, 1'b1, 1'b0);
        incs(23);
        cyc(1'b0, 1'b1, 1'b0);
        incs(59);
        cyc(1'b0, 1'b1, 1'b0);
        chk("zero", now(), 32'h00000000);
        ticks(9, "c1");
        chk("c1_pre", now(), 32'h00000009);
        ticks(1, "c1b");
        chk("c1_post", now(), 32'h00000010);

        // Carry 00:09:59 -> 00:10:00
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        incs(9);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(59, "c2");
        chk("c2_pre", now(), 32'h00000959);
        ticks(1, "c2b");
        chk("c2_post", now(), 32'h00001000);

        // Carry 09:59:59 -> 10:00:00
        cyc(1'b0, 1'b1, 1'b0);
        incs(9);
        cyc(1'b0, 1'b1, 1'b0);
        incs(49);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(59, "c3");
        chk("c3_pre", now(), 32'h00095959);
        ticks(1, "c3b");
        chk("c3_post", now(), 32'h00100000);

        // mode+inc in SET_HR: mode wins
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        chk("mode_inc_state", {30'd0, state}, 32'd2);
        chk("mode_inc_time", now(), 32'h00100000);
        cyc(1'b0, 1'b1, 1'b0);

        // mode+tick in RUN at 00:00:07
        cyc(1'b0, 1'b1, 1'b0);
        incs(14);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(7, "m_t");
        chk("mode_tick_pre", now(), 32'h00000007);
        cyc(1'b1, 1'b1, 1'b0);
        chk("mode_tick_time", now(), 32'h00000008);
        chk("mode_tick_state", {30'd0, state}, 32'd1);

        // Reset while in SET_MIN at 05:17:33
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        ticks(33, "r");
        cyc(1'b0, 1'b1, 1'b0);
        incs(5);
        cyc(1'b0, 1'b1, 1'b0);
        incs(17);
        chk("preset_time", now(), 32'h00051733);
        chk("preset_state", {30'd0, state}, 32'd2);
        rst = 1'b0;
        cyc(1'b1, 1'b1, 1'b1);
        chk("rst_mid_time", now(), 32'h00123400);
        chk("rst_mid_state", {30'd0, state}, 32'd0);
        chk("rst_mid_day", {31'd0, day_pulse}, 32'd0);
        rst = 1'b1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
